sqrt_rr_scheduler: RTL and testbench
====================================

Name: sqrt_rr_scheduler

Overview:
- Round-robin scheduler that shares one multi-cycle square-root datapath among NREQ requesters.
- Each requester submits an operand pair (a, b) with a valid/ready handshake.
- The scheduler latches the winner's operands, pulses start to the datapath and waits a fixed OP_CYCLES.
- It then captures the datapath output and returns it on a single tagged valid/ready response port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester-id width; must equal ceil(log2(NREQ)).
- WIDTH, 16, operand and result width.
- OP_CYCLES, 8, datapath latency in clk cycles after the start pulse; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept strobe; at most one bit high.
- req_a  in  NREQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed operand B; same packing as req_a.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  WIDTH  datapath result.
- rsp_id  out  IDW  index of the requester that owns rsp_data.
- sq_start  out  1  one-cycle start pulse to the datapath.
- sq_inA  out  WIDTH  operand A to the datapath; held stable for the whole operation.
- sq_inB  out  WIDTH  operand B to the datapath; held stable for the whole operation.
- sq_out  in  WIDTH  datapath result; sampled once per operation.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. A binary state register is sufficient.
- Reset (asynchronous, any state):
  - state=IDLE, all outputs 0, internal cycle counter=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has top priority first.
  - An in-flight operation is discarded; no response is produced for it.
- IDLE:
  - Winner = first i with req_valid[i]=1, searched in order last+1, last+2, ... modulo NREQ.
  - req_ready[winner]=1 combinationally, in IDLE only; all other req_ready bits are 0.
  - A transfer occurs on a clk edge where req_valid[i] & req_ready[i].
  - On transfer: latch a, b and id into sq_inA, sq_inB and rsp_id; set last=winner; go to ISSUE.
  - No valid requests: remain in IDLE with outputs unchanged.
- ISSUE: sq_start=1 for exactly one cycle; counter cleared to 0; go to WAIT.
- WAIT:
  - Counter increments every cycle.
  - On the cycle where counter==OP_CYCLES-1: register sq_out into rsp_data, go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_id are held stable until accepted.
  - On rsp_ready=1, go to IDLE. rsp_valid deasserts next cycle; rsp_data and rsp_id keep their last values.
  - No new request is accepted while in RESP.
- Timing (accept edge = cycle T):
  - sq_start high during cycle T+1.
  - sq_out sampled at the end of cycle T+1+OP_CYCLES.
  - rsp_valid high from cycle T+2+OP_CYCLES.
  - With rsp_ready held at 1, the next accept occurs at the earliest OP_CYCLES+3 cycles after the previous accept.
- Fairness: a requester holding req_valid high is served within NREQ-1 other operations.
- Requester rules:
  - A requester may drop req_valid before being granted; nothing is latched for it.
  - Operands are sampled only on the transfer edge; later changes to req_a/req_b have no effect.
- Arithmetic: none in the scheduler. The result is passed through unmodified at WIDTH bits.
- Counter width: ceil(log2(OP_CYCLES))+1 bits; it never wraps within an operation.
- rsp_ready=1 outside RESP is ignored.

Test Plan:
- Single request: reset, then req0 valid with a=3, b=4; bench datapath model returns 5 after OP_CYCLES=8.
  -> sq_start pulse at T+1; rsp_valid=1, rsp_data=5, rsp_id=0 at T+10.
- Contention: all four requesters valid from reset with (a,b)=(3,4), (5,12), (8,15), (7,24); rsp_ready=1.
  -> grants in order 0,1,2,3; responses 5,13,17,25 with matching ids.
  -> accepts spaced exactly 11 cycles apart.
- Round-robin rotation: after req2 is served, req1 and req3 both valid.
  -> req3 granted before req1.
- Response backpressure: rsp_ready=0 for 20 cycles in RESP.
  -> rsp_valid, rsp_data and rsp_id stay stable; req_ready stays 0.
  -> IDLE one cycle after rsp_ready=1.
- Reset mid-operation: assert reset during WAIT at counter=3.
  -> all outputs 0 immediately; no response for the aborted operation.
  -> after release, req0 (still valid) granted first with correct result.
- Request withdrawal: req1 pulses valid for one cycle while the scheduler is in WAIT.
  -> never granted; no response with rsp_id=1.

Source files
------------

// File: rtl/sqrt_rr_scheduler.sv
// sqrt_rr_scheduler: round-robin arbiter sharing one fixed-latency sqrt datapath among NREQ requesters
//   clk, reset            : clock and asynchronous active-high reset
//   req_valid/ready/a/b   : per-requester operand handshake, operands packed WIDTH bits per requester
//   rsp_valid/ready/data/id : tagged result handshake
//   sq_start/inA/inB/out  : datapath start pulse, held operands, and result sampled after OP_CYCLES
//   busy                  : high whenever an operation is in progress
module sqrt_rr_scheduler #(
  parameter int NREQ      = 4,
  parameter int IDW       = 2,
  parameter int WIDTH     = 16,
  parameter int OP_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  sq_start,
  output logic [WIDTH-1:0]      sq_inA,
  output logic [WIDTH-1:0]      sq_inB,
  input  logic [WIDTH-1:0]      sq_out,
  output logic                  busy
);
  localparam int CW = $clog2(OP_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [IDW-1:0] last_q, last_d, id_q, id_d, win, idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic found;
  // first valid requester strictly after the last winner, wrapping modulo NREQ
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  // grant is gated by reset so every output reads 0 while reset is held
  assign req_ready = (state_q == IDLE && found && !reset) ? NREQ'(1) << win : '0;
  assign sq_start  = state_q == ISSUE;
  assign rsp_valid = state_q == RESP;
  assign busy      = state_q != IDLE;
  assign sq_inA    = a_q;
  assign sq_inB    = b_q;
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    data_d = data_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = ISSUE;
        last_d = win;
        id_d = win;
        a_d = req_a[win*WIDTH +: WIDTH];
        b_d = req_b[win*WIDTH +: WIDTH];
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(OP_CYCLES - 1)) begin
          state_d = RESP;
          data_d = sq_out;
        end
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= IDW'(NREQ - 1);
      id_q <= '0;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_sqrt_rr_scheduler.sv
// tb_sqrt_rr_scheduler: randomized self-checking bench with a round-robin reference model and hypotenuse datapath model
module tb_sqrt_rr_scheduler;
  localparam int NREQ = 4, IDW = 2, W = 16, OP = 8;
  logic clk, reset, rsp_ready, rsp_valid, sq_start, busy;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [W-1:0] rsp_data, sq_inA, sq_inB, sq_out, junk;
  logic [IDW-1:0] rsp_id;
  int n_cmp = 0, n_err = 0, m_last = NREQ - 1, k = 0;
  time t_acc;

  sqrt_rr_scheduler #(.NREQ(NREQ), .IDW(IDW), .WIDTH(W), .OP_CYCLES(OP)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .sq_start(sq_start), .sq_inA(sq_inA),
    .sq_inB(sq_inB), .sq_out(sq_out), .busy(busy));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int isqrt(input longint x);
    longint r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return int'(r);
  endfunction

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] m);
    for (int i = 1; i <= NREQ; i++) if (m[(last + i) % NREQ]) return (last + i) % NREQ;
    return 0;
  endfunction

  // datapath model: the true hypotenuse appears only in the cycle OP cycles after the start pulse
  always @(posedge clk or posedge reset) begin
    if (reset) k <= 0;
    else k <= sq_start ? 1 : (k > 0 ? k + 1 : 0);
    junk <= W'($urandom);
  end
  assign sq_out = (k == OP) ? W'(isqrt(longint'(sq_inA) * sq_inA + longint'(sq_inB) * sq_inB)) : junk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    m_last = NREQ - 1;
  endtask

  task automatic run_op(input int stall, input int pulse);
    int exp_id, ea, eb, n, bad_start, bad_rdy;
    logic [W-1:0] ed;
    #1;
    exp_id = rr_pick(m_last, req_valid);
    ea = int'(req_a[exp_id*W +: W]);
    eb = int'(req_b[exp_id*W +: W]);
    ed = W'(isqrt(longint'(ea) * ea + longint'(eb) * eb));
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== NREQ'(1 << exp_id)) begin
      n_err++;
      $display("FAIL grant: busy=%b req_ready=%b, required busy=0 req_ready=%b", busy, req_ready, NREQ'(1 << exp_id));
    end
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    m_last = exp_id;
    req_valid[exp_id] = 1'b0;
    req_a[exp_id*W +: W] = W'($urandom_range(0, 255));
    req_b[exp_id*W +: W] = W'($urandom_range(0, 255));
    n_cmp++;
    if (sq_start !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL issue: sq_start=%b busy=%b, required 1 1", sq_start, busy);
    end
    n = 0;
    bad_start = 0;
    bad_rdy = 0;
    while (rsp_valid !== 1'b1 && n < 40) begin
      rsp_ready = 1'($urandom);
      if (pulse >= 0) req_valid[pulse] = (n == 3);
      @(negedge clk);
      n++;
      if (sq_start !== 1'b0) bad_start++;
      if (req_ready !== '0) bad_rdy++;
    end
    n_cmp++;
    if (n != OP + 1) begin
      n_err++;
      $display("FAIL latency: rsp_valid after %0d cycles, required %0d", n, OP + 1);
    end
    n_cmp++;
    if (bad_start != 0 || bad_rdy != 0) begin
      n_err++;
      $display("FAIL busy_outputs: extra sq_start=%0d req_ready=%0d, required 0 0", bad_start, bad_rdy);
    end
    n_cmp++;
    if (rsp_data !== ed || rsp_id !== IDW'(exp_id)) begin
      n_err++;
      $display("FAIL result: data=%0d id=%0d, required data=%0d id=%0d", rsp_data, rsp_id, ed, exp_id);
    end
    for (int s = 0; s < stall; s++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_id !== IDW'(exp_id) || req_ready !== '0) begin
        n_err++;
        $display("FAIL hold: valid=%b data=%0d id=%0d req_ready=%b, required 1 %0d %0d 0", rsp_valid, rsp_data, rsp_id, req_ready, ed, exp_id);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== ed || rsp_id !== IDW'(exp_id)) begin
      n_err++;
      $display("FAIL release: busy=%b valid=%b data=%0d id=%0d, required 0 0 %0d %0d", busy, rsp_valid, rsp_data, rsp_id, ed, exp_id);
    end
  endtask

  task automatic test_reset();
    req_valid = '1;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, sq_start, busy, req_ready, sq_inA, sq_inB, rsp_data, rsp_id} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: valid=%b start=%b busy=%b ready=%b, required all 0", rsp_valid, sq_start, busy, req_ready);
    end
    req_valid = '0;
    reset = 0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      n_err++;
      $display("FAIL reset_idle: busy=%b req_ready=%b, required 0 0", busy, req_ready);
    end
  endtask

  task automatic test_single();
    req_a[0*W +: W] = 3;
    req_b[0*W +: W] = 4;
    req_valid = 4'b0001;
    run_op(0, -1);
  endtask

  task automatic test_contention();
    time prev;
    int av[4] = '{3, 5, 8, 7};
    int bv[4] = '{4, 12, 15, 24};
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = W'(av[i]);
      req_b[i*W +: W] = W'(bv[i]);
    end
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      prev = t_acc;
      run_op(0, -1);
      if (i > 0) begin
        n_cmp++;
        if (t_acc - prev != 110) begin
          n_err++;
          $display("FAIL accept_gap: %0t, required 110", t_acc - prev);
        end
      end
    end
  endtask

  task automatic test_rotation();
    req_valid = 4'b0100;
    run_op(0, -1);
    req_valid = 4'b1010;
    run_op(0, -1);
    run_op(0, -1);
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0101;
    run_op(20, -1);
    run_op(0, -1);
  endtask

  task automatic test_reset_mid();
    req_a[2*W +: W] = 20;
    req_b[2*W +: W] = 21;
    req_a[0*W +: W] = 9;
    req_b[0*W +: W] = 40;
    req_valid = 4'b0101;
    #1;
    @(posedge clk);
    @(negedge clk);
    repeat (4) @(negedge clk);
    reset = 1;
    #1;
    n_cmp++;
    if ({rsp_valid, sq_start, busy, req_ready, sq_inA, sq_inB, rsp_data, rsp_id} !== '0) begin
      n_err++;
      $display("FAIL reset_async: valid=%b start=%b busy=%b ready=%b, required all 0", rsp_valid, sq_start, busy, req_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: valid=%b busy=%b, required 0 0", rsp_valid, busy);
    end
    reset = 0;
    m_last = NREQ - 1;
    run_op(0, -1);
    run_op(0, -1);
  endtask

  task automatic test_withdraw();
    req_valid = 4'b0001;
    run_op(0, 1);
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (req_ready !== '0 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL withdraw: ready=%b busy=%b valid=%b, required 0 0 0", req_ready, busy, rsp_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < NREQ; r++) begin
        req_a[r*W +: W] = W'($urandom_range(0, 255));
        req_b[r*W +: W] = W'($urandom_range(0, 255));
      end
      req_valid = req_valid | NREQ'($urandom_range(0, 15));
      if (req_valid == '0) req_valid = NREQ'($urandom_range(1, 15));
      run_op($urandom_range(0, 3), -1);
    end
  endtask

  initial begin
    reset = 0;
    rsp_ready = 0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    t_acc = 0;
    #2 reset = 1;
    test_reset();
    test_single();
    test_contention();
    test_rotation();
    test_backpressure();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
